// File: rtl/seg_monitor.sv
// Seven-segment / LED-bank observer: debounces the display, decodes the digit and
// classifies each accepted change as a step, a jump or an illegal state.
module seg_monitor #(
  parameter int STABLE_CYC = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [6:0] seg_in,
  input  logic [7:0] led_in,
  output logic [2:0] value,
  output logic       valid,
  output logic       step,
  output logic       jump,
  output logic       err,
  output logic [7:0] step_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYC);

  logic [1:0]  state_q, state_d;
  logic [14:0] cand_q, cand_d;
  logic [3:0]  run_q, run_d;
  logic [2:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        step_q, step_d;
  logic        jump_q, jump_d;
  logic        err_q, err_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [14:0] samp;
  logic        same;
  logic        accept;
  logic [2:0]  dig;
  logic        dig_ok;
  logic        legal;

  // Run tracking: a saturated run matching the candidate has already been accepted.
  always_comb begin
    samp   = {seg_in, led_in};
    same   = (samp == cand_q);
    cand_d = cand_q;
    run_d  = run_q;
    if (same) begin
      if (run_q != RUN_MAX) run_d = run_q + 4'd1;
    end else begin
      cand_d = samp;
      run_d  = 4'd1;
    end
    accept = (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));
  end

  always_comb begin
    dig    = 3'd0;
    dig_ok = 1'b1;
    case (seg_in)
      7'h3F: dig = 3'd0;
      7'h06: dig = 3'd1;
      7'h5B: dig = 3'd2;
      7'h4F: dig = 3'd3;
      7'h66: dig = 3'd4;
      7'h6D: dig = 3'd5;
      7'h7D: dig = 3'd6;
      7'h07: dig = 3'd7;
      default: dig_ok = 1'b0;
    endcase
    legal = dig_ok && (led_in == (8'd1 << dig));
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    valid_d    = valid_q;
    step_d     = 1'b0;
    jump_d     = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      if (!legal) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
        state_d = ST_FAULT;
      end else if (state_q != ST_TRACK) begin
        value_d = dig;
        valid_d = 1'b1;
        state_d = ST_TRACK;
      end else if (dig == value_q + 3'd1) begin
        // 3-bit add wraps, so 7->0 is a step
        value_d = dig;
        step_d  = 1'b1;
      end else if (dig != value_q) begin
        value_d = dig;
        jump_d  = 1'b1;
      end
    end
    step_cnt_d = step_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (step_d && step_cnt_q != 8'hFF) step_cnt_d = step_cnt_q + 8'd1;
    if (err_d && err_cnt_q != 8'hFF)   err_cnt_d  = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= ST_EMPTY;
      cand_q     <= '0;
      run_q      <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      jump_q     <= 1'b0;
      err_q      <= 1'b0;
      step_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      jump_q     <= jump_d;
      err_q      <= err_d;
      step_cnt_q <= step_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign step     = step_q;
  assign jump     = jump_q;
  assign err      = err_q;
  assign step_cnt = step_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_seg_monitor.sv
// Directed bench for seg_monitor (STABLE_CYC=2); outputs sampled 1ns after each edge.
module tb_seg_monitor;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [6:0] seg_in = '0;
  logic [7:0] led_in = '0;
  logic [2:0] value;
  logic       valid, step, jump, err;
  logic [7:0] step_cnt, err_cnt;
  int n_chk = 0;
  int n_fail = 0;

  seg_monitor #(.STABLE_CYC(2)) dut (
    .clk(clk), .clr_n(clr_n), .seg_in(seg_in), .led_in(led_in),
    .value(value), .valid(valid), .step(step), .jump(jump), .err(err),
    .step_cnt(step_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; default: return 7'h07;
    endcase
  endfunction

  task automatic cyc(input logic [6:0] s, input logic [7:0] l);
    seg_in = s;
    led_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    cyc(7'h7D, 8'h40);
    cyc(7'h7D, 8'h40);
    n_chk++;
    if ({value, valid, step, jump, err} !== 7'd0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0", {value, valid, step, jump, err});
    end
    n_chk++;
    if ({step_cnt, err_cnt} !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnts got=%h exp=0", {step_cnt, err_cnt});
    end
  endtask

  task automatic test_first_accept;
    clr_n = 1'b1;
    cyc(7'h7D, 8'h40);
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL first_early valid got=%b exp=0", valid); end
    cyc(7'h7D, 8'h40);
    n_chk++;
    if ({valid, value, step, jump} !== {1'b1, 3'd6, 2'b00}) begin
      n_fail++; $display("FAIL first_accept got v=%b val=%0d s=%b j=%b exp v=1 val=6 s=0 j=0", valid, value, step, jump);
    end
  endtask

  task automatic test_wrap_steps;
    cyc(7'h07, 8'h80);
    n_chk++;
    if (step !== 1'b0) begin n_fail++; $display("FAIL step67_early got=%b exp=0", step); end
    cyc(7'h07, 8'h80);
    n_chk++;
    if ({step, value} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL step67 got s=%b val=%0d exp s=1 val=7", step, value);
    end
    cyc(7'h07, 8'h80);
    n_chk++;
    if (step !== 1'b0) begin n_fail++; $display("FAIL step67_pulse_width got=%b exp=0", step); end
    cyc(7'h3F, 8'h01);
    cyc(7'h3F, 8'h01);
    n_chk++;
    if ({step, value, jump} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL step70 got s=%b val=%0d j=%b exp s=1 val=0 j=0", step, value, jump);
    end
    cyc(7'h3F, 8'h01);
    n_chk++;
    if (step_cnt !== 8'd2) begin n_fail++; $display("FAIL step_cnt2 got=%0d exp=2", step_cnt); end
  endtask

  task automatic test_glitch;
    cyc(7'h06, 8'h02); cyc(7'h06, 8'h02);
    cyc(7'h5B, 8'h04); cyc(7'h5B, 8'h04);
    n_chk++;
    if ({value, step_cnt} !== {3'd2, 8'd4}) begin
      n_fail++; $display("FAIL glitch_setup got val=%0d cnt=%0d exp val=2 cnt=4", value, step_cnt);
    end
    cyc(7'h66, 8'h10);
    n_chk++;
    if ({step, jump, err, value} !== {3'b000, 3'd2}) begin
      n_fail++; $display("FAIL glitch_cycle got sje=%b val=%0d exp sje=000 val=2", {step, jump, err}, value);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(7'h5B, 8'h04);
      n_chk++;
      if ({step, jump, err, value, valid} !== {3'b000, 3'd2, 1'b1}) begin
        n_fail++; $display("FAIL glitch_recover[%0d] got sje=%b val=%0d v=%b exp sje=000 val=2 v=1", i, {step, jump, err}, value, valid);
      end
    end
  endtask

  task automatic test_jump;
    cyc(7'h4F, 8'h08); cyc(7'h4F, 8'h08);
    n_chk++;
    if ({step, value, step_cnt} !== {1'b1, 3'd3, 8'd5}) begin
      n_fail++; $display("FAIL jump_setup got s=%b val=%0d cnt=%0d exp s=1 val=3 cnt=5", step, value, step_cnt);
    end
    cyc(7'h5B, 8'h04); cyc(7'h5B, 8'h04);
    n_chk++;
    if ({jump, step, value, step_cnt} !== {2'b10, 3'd2, 8'd5}) begin
      n_fail++; $display("FAIL jump got j=%b s=%b val=%0d cnt=%0d exp j=1 s=0 val=2 cnt=5", jump, step, value, step_cnt);
    end
    cyc(7'h5B, 8'h04);
    n_chk++;
    if (jump !== 1'b0) begin n_fail++; $display("FAIL jump_pulse_width got=%b exp=0", jump); end
  endtask

  task automatic test_fault;
    cyc(7'h06, 8'h04);
    n_chk++;
    if ({err, valid} !== 2'b01) begin n_fail++; $display("FAIL fault_early got e=%b v=%b exp e=0 v=1", err, valid); end
    cyc(7'h06, 8'h04);
    n_chk++;
    if ({err, valid, value, err_cnt} !== {2'b10, 3'd2, 8'd1}) begin
      n_fail++; $display("FAIL fault got e=%b v=%b val=%0d ecnt=%0d exp e=1 v=0 val=2 ecnt=1", err, valid, value, err_cnt);
    end
    cyc(7'h06, 8'h04);
    n_chk++;
    if ({err, err_cnt} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL fault_hold got e=%b ecnt=%0d exp e=0 ecnt=1", err, err_cnt); end
    cyc(7'h4F, 8'h08); cyc(7'h4F, 8'h08);
    n_chk++;
    if ({valid, value, step, jump, step_cnt} !== {1'b1, 3'd3, 2'b00, 8'd5}) begin
      n_fail++; $display("FAIL fault_recover got v=%b val=%0d s=%b j=%b cnt=%0d exp v=1 val=3 s=0 j=0 cnt=5", valid, value, step, jump, step_cnt);
    end
  endtask

  task automatic test_saturate;
    int d = 3;
    int pulses = 0;
    for (int i = 0; i < 300; i++) begin
      d = (d + 1) % 8;
      cyc(seg_of(d), 8'(1 << d));
      cyc(seg_of(d), 8'(1 << d));
      if (step === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 300) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=300", pulses); end
    n_chk++;
    if ({step_cnt, value} !== {8'd255, 3'(d)}) begin
      n_fail++; $display("FAIL sat_cnt got cnt=%0d val=%0d exp cnt=255 val=%0d", step_cnt, value, d);
    end
    clr_n = 1'b0;
    cyc(seg_of(d), 8'(1 << d));
    n_chk++;
    if ({value, valid, step, jump, err, step_cnt, err_cnt} !== 23'd0) begin
      n_fail++; $display("FAIL sat_reset got=%h exp=0", {value, valid, step, jump, err, step_cnt, err_cnt});
    end
  endtask

  task automatic test_reset_mid_run;
    clr_n = 1'b1;
    cyc(7'h5B, 8'h04);
    clr_n = 1'b0;
    cyc(7'h5B, 8'h04);
    clr_n = 1'b1;
    cyc(7'h5B, 8'h04);
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midrun_discard valid got=%b exp=0", valid); end
    cyc(7'h5B, 8'h04);
    n_chk++;
    if ({valid, value, step, jump} !== {1'b1, 3'd2, 2'b00}) begin
      n_fail++; $display("FAIL midrun_accept got v=%b val=%0d s=%b j=%b exp v=1 val=2 s=0 j=0", valid, value, step, jump);
    end
  endtask

  initial begin
    test_reset;
    test_first_accept;
    test_wrap_steps;
    test_glitch;
    test_jump;
    test_fault;
    test_saturate;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_monitor.md
SEG_MONITOR -- requirements
Module: seg_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 2, meaning the number of consecutive identical samples required before a display state is accepted (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-003 SHALL have port clr_n, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-004 SHALL have port seg_in, input, 7, observed segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-005 SHALL have port led_in, input, 8, observed LED bank.
REQ-006 SHALL have port value, output, 3, last accepted legal digit.
REQ-007 SHALL have port valid, output, 1, high while value reflects an accepted legal state.
REQ-008 SHALL have port step, output, 1, one-cycle pulse on an accepted +1 (mod 8) advance.
REQ-009 SHALL have port jump, output, 1, one-cycle pulse on an accepted legal change other than +1.
REQ-010 SHALL have port err, output, 1, one-cycle pulse on an accepted illegal state.
REQ-011 SHALL have port step_cnt, output, 8, count of step pulses.
REQ-012 SHALL have port err_cnt, output, 8, count of err pulses.

Function
REQ-013 SHALL decode seg_in by this table: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07; any other pattern is illegal.
REQ-014 SHALL treat a sample as legal only when seg_in decodes to digit d and led_in == 8'b1 << d; any other sample is illegal.
REQ-015 SHALL hold a candidate register {seg_in, led_in} and a run counter: a sample equal to the candidate increments the counter, saturating at STABLE_CYC; a differing sample loads the candidate and sets the counter to 1.
REQ-016 SHALL accept the candidate on the edge at which the run counter first reaches STABLE_CYC; each stable run is accepted exactly once.
REQ-017 SHALL update all outputs on the accepting edge (zero extra latency); step, jump and err SHALL be high for exactly the following cycle.
REQ-018 SHALL implement the states EMPTY (valid=0, no legal state yet), TRACK (valid=1) and FAULT (valid=0, after an illegal state).
REQ-019 In EMPTY or FAULT, an accepted legal digit d SHALL set value=d and valid=1, move to TRACK, and SHALL NOT pulse step or jump.
REQ-020 In TRACK, an accepted legal d == (value+1) mod 8 SHALL set value=d and pulse step; the transition 7->0 counts as a step.
REQ-021 In TRACK, an accepted legal d != value and d != (value+1) mod 8 SHALL set value=d and pulse jump.
REQ-022 In TRACK, an accepted legal d == value (a glitch that recovers) SHALL produce no pulse and no change.
REQ-023 In any state, an accepted illegal sample SHALL pulse err, clear valid, hold value, and move to FAULT.
REQ-024 step_cnt and err_cnt SHALL increment by 1 with each pulse and saturate at 255.
REQ-025 Glitches shorter than STABLE_CYC samples SHALL produce no output change.

Reset
REQ-026 While clr_n=0 at an edge, the block SHALL set state=EMPTY, value=0, valid=0, step=jump=err=0, step_cnt=err_cnt=0, candidate=0 and run counter=0, overriding all other activity.
REQ-027 The first edge with clr_n=1 SHALL count as sample 1 of a new run; reset asserted mid-run SHALL discard the run.

Verification
REQ-028 Reset, then hold seg_in=7'h7D, led_in=8'h40 (STABLE_CYC=2) -> valid=1 and value=6 after the 2nd sampled edge, with no step pulse.
REQ-029 From value=6, apply 7'h07/8'h80 and then 7'h3F/8'h01, each held 3 cycles -> two step pulses (6->7, 7->0) and step_cnt=2.
REQ-030 From value=2, apply 7'h66/8'h10 for one cycle, then 7'h5B/8'h04 -> no pulses, value stays 2.
REQ-031 From value=3, apply 7'h5B/8'h04 (a load back to 2) held 2 cycles -> jump pulse, value=2, step_cnt unchanged.
REQ-032 Apply 7'h06/8'h04 (LED mismatch) held 2 cycles -> err pulse, valid=0, err_cnt=1; then apply legal 7'h4F/8'h08 -> valid=1, value=3, no step.
REQ-033 Drive 300 accepted +1 steps -> step_cnt saturates at 255; assert clr_n=0 for one edge -> all outputs 0 on that edge.
